imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the RV32I core's instruction memory. Accepts a length-prefixed, checksummed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory through a dedicated write port. Holds the core in reset until a complete image with a correct checksum has been written.

## Interface
- BASE_ADDR, 20'h00000, byte address of the first written word (word-aligned)
- MAX_WORDS, 1024, largest accepted image length in words

- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte
- reload  input  1  restart loading; sampled only in DONE/ERR
- imem_we  output  1  one-cycle instruction-memory write strobe
- imem_addr  output  20  byte address of the write
- imem_wdata  output  32  instruction word
- core_reset_n  output  1  active-low reset to the core
- done  output  1  image loaded and verified (sticky)
- error  output  1  length or checksum failure (sticky)

## Operation
- Stream format: LEN_LO, LEN_HI, then LEN×4 data bytes, then CK. CK = XOR of every preceding byte, length bytes included.
- A byte is accepted on a rising edge with in_valid & in_ready. No other event consumes a byte.
- FSM states: LEN0, LEN1, DATA, CKSUM, DONE, ERR.
  - LEN0: accept byte -> len[7:0]; clear XOR accumulator, word index, and byte index. Go to LEN1.
  - LEN1: accept byte -> len[15:8]. If the full length > MAX_WORDS, go to ERR. If length == 0, go to CKSUM. Otherwise go to DATA.
  - DATA: each accepted byte k (k = 0..3 within a word) is placed at bits [8k+7:8k].
    - On the 4th byte, the assembled word is registered into imem_wdata and imem_addr = BASE_ADDR + word_idx×4 (truncated to 20 bits).
    - imem_we pulses high for exactly the next cycle; word_idx then increments.
    - After word len−1 is complete, go to CKSUM.
  - CKSUM: accept byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE: done=1, core_reset_n=1, in_ready=0.
  - ERR: error=1, core_reset_n=0, in_ready=0.
- in_ready = 1 in LEN0, LEN1, DATA, CKSUM; 0 in DONE and ERR.
- reload=1 in DONE or ERR: next state LEN0. done, error, and core_reset_n return to 0 on that same edge. reload is ignored in all other states.
- The accumulator XORs every accepted byte except CK itself.
- Reset values: state LEN0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset_n=0, done=0, error=0.
- Asynchronous reset mid-load discards the partial word and counters. No write strobe is emitted after reset asserts.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- The loader accepts one byte per cycle at full rate; in_valid gaps of any length are tolerated.
- Last data byte accepted at edge t: imem_we is high during cycle t..t+1.
  - The earliest CK acceptance is edge t+1.
  - core_reset_n/done rise at that edge.
  - The last memory write therefore always precedes core release.
- Length error: error rises on the same edge that accepts LEN_HI. No imem_we is ever asserted for that image.
- Back-to-back words: imem_we is high at most once per 4 accepted bytes, never two cycles in a row.
- word_idx is 16 bits. Address wrap above 20 bits is not reachable for MAX_WORDS ≤ 2^18.

## Test plan
- Nominal load, stream 02 00 13 05 A0 00 93 05 B0 00 92:
  - writes (0x00000, 0x00A00513) then (0x00004, 0x00B00593);
  - done=1 and core_reset_n=1 on the edge accepting 0x92;
  - in_ready=0 afterwards.
- Same stream with CK=0x93: both writes occur; error=1, done=0, core_reset_n stays 0, in_ready=0.
- Length edge cases:
  - 00 00 00 -> done with zero writes;
  - 01 04 (1025 words) -> error on the LEN_HI edge, zero writes, later bytes not accepted.
- Nominal stream with 0–5 random idle cycles between bytes -> identical write sequence and completion; imem_we never high two consecutive cycles.
- reset_n low mid-DATA after 2 bytes of word 0, then a full nominal stream:
  - no write strobe during or after the reset;
  - the full stream afterwards loads identically to the nominal case.
- In DONE, pulse reload, then stream 01 00 EF BE AD DE <CK=0x01^0xEF^0xBE^0xAD^0xDE=0x23>:
  - core_reset_n, done, error, and in_ready reach their restart values on the reload edge (0, 0, 0, 1);
  - write (0x00000, 0xDEADBEEF);
  - done returns to 1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed, XOR-checksummed byte stream into imem.
// Holds the core in reset until a verified image has been written.
module imem_loader #(
    parameter logic [19:0] BASE_ADDR = 20'h00000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave stream,
    input  logic         reload,
    output logic         imem_we,
    output logic [19:0]  imem_addr,
    output logic [31:0]  imem_wdata,
    output logic         core_reset_n,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CKSUM,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  acc;
    logic [23:0] wbuf;
    logic        ready;
    logic        accept;
    logic [15:0] len_full;
    logic        last_byte;

    assign stream.in_ready = ready;
    assign accept          = stream.in_valid & ready;
    assign len_full        = {stream.in_data, len[7:0]};
    assign last_byte       = (byte_idx == 2'd3) &&
                             (word_idx == len - 16'd1);

    always_comb begin
        state_n = state;
        unique case (state)
            LEN0: begin
                if (accept) state_n = LEN1;
            end
            LEN1: begin
                if (accept) begin
                    if (int'(len_full) > MAX_WORDS)
                        state_n = ERR;
                    else if (len_full == 16'd0)
                        state_n = CKSUM;
                    else
                        state_n = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte) state_n = CKSUM;
            end
            CKSUM: begin
                if (accept)
                    state_n = (stream.in_data == acc) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (reload) state_n = LEN0;
            end
            default: state_n = LEN0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= LEN0;
            len          <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            acc          <= '0;
            wbuf         <= '0;
            ready        <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_reset_n <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            imem_we      <= 1'b0;
            // Status flags follow the state being entered, so they move
            // on the same edge as the accepting byte or the reload.
            ready        <= (state_n != DONE) && (state_n != ERR);
            done         <= (state_n == DONE);
            error        <= (state_n == ERR);
            core_reset_n <= (state_n == DONE);
            if (accept) begin
                unique case (state)
                    LEN0: begin
                        len[7:0] <= stream.in_data;
                        acc      <= stream.in_data;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                    LEN1: begin
                        len[15:8] <= stream.in_data;
                        acc       <= acc ^ stream.in_data;
                    end
                    DATA: begin
                        acc      <= acc ^ stream.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx != 2'd3) begin
                            wbuf[{byte_idx, 3'b000} +: 8] <= stream.in_data;
                        end else begin
                            imem_wdata <= {stream.in_data, wbuf};
                            imem_addr  <= BASE_ADDR +
                                          20'({word_idx, 2'b00});
                            imem_we    <= 1'b1;
                            word_idx   <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus
// time and popped by a monitor whenever the write strobe fires.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [19:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset_n;
    logic        done;
    logic        error;

    imem_loader_if sif ();

    imem_loader #(
        .BASE_ADDR (20'h00000),
        .MAX_WORDS (1024)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stream       (sif.slave),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_err = 0;
    int unsigned n_writes = 0;
    logic [51:0] exp_q[$];
    logic [7:0]  stim[$];
    logic        prev_we = 1'b0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {imem_addr, imem_wdata}, 52'h0);
            end else begin
                check("write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
            if (prev_we) check("we_back_to_back", 1, 0);
        end
        prev_we = (imem_we === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input int idle);
        bit ok;
        sif.in_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        sif.in_valid = 1'b1;
        sif.in_data  = b;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sif.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
    endtask

    task automatic send_stim(input int max_idle);
        while (stim.size() > 0) begin
            send_byte(stim.pop_front(), $urandom_range(max_idle, 0));
        end
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        sif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic load_nominal();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h93, 8'h05, 8'hB0, 8'h00};
        exp_q.push_back({20'h00000, 32'h00A00513});
        exp_q.push_back({20'h00004, 32'h00B00593});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   sif.in_ready, 1);
        check({tag, "_we"},    imem_we, 0);
        check({tag, "_addr"},  imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_core"},  core_reset_n, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   error, 0);
    endtask

    int unsigned w0;

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        do_reset();
        check_reset_vals("reset");

        // Nominal load at full rate
        w0 = n_writes;
        load_nominal();
        send_stim(0);
        send_byte(8'h92, 0);
        check("nom_done", done, 1);
        check("nom_core", core_reset_n, 1);
        check("nom_err", error, 0);
        check("nom_rdy", sif.in_ready, 0);
        check("nom_writes", n_writes - w0, 2);
        check("nom_q_empty", exp_q.size(), 0);

        // Bad checksum
        do_reset();
        w0 = n_writes;
        load_nominal();
        send_stim(0);
        send_byte(8'h93, 0);
        repeat (2) @(posedge clk);
        #1;
        check("badck_err", error, 1);
        check("badck_done", done, 0);
        check("badck_core", core_reset_n, 0);
        check("badck_rdy", sif.in_ready, 0);
        check("badck_writes", n_writes - w0, 2);

        // Zero-length image
        do_reset();
        w0 = n_writes;
        stim = '{8'h00, 8'h00, 8'h00};
        send_stim(0);
        check("zero_done", done, 1);
        check("zero_core", core_reset_n, 1);
        check("zero_writes", n_writes - w0, 0);

        // Length 1025 words exceeds the limit
        do_reset();
        w0 = n_writes;
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("len_err", error, 1);
        check("len_rdy", sif.in_ready, 0);
        sif.in_valid = 1'b1;
        sif.in_data  = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        check("len_rdy_hold", sif.in_ready, 0);
        check("len_err_hold", error, 1);
        check("len_done", done, 0);
        check("len_writes", n_writes - w0, 0);

        // Nominal load with random idle gaps
        do_reset();
        w0 = n_writes;
        load_nominal();
        send_stim(5);
        send_byte(8'h92, $urandom_range(5, 0));
        check("gap_done", done, 1);
        check("gap_core", core_reset_n, 1);
        check("gap_writes", n_writes - w0, 2);

        // Reset mid-word, then a full load
        do_reset();
        w0 = n_writes;
        stim = '{8'h02, 8'h00, 8'h13, 8'h05};
        send_stim(0);
        do_reset();
        check_reset_vals("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_writes", n_writes - w0, 0);
        load_nominal();
        send_stim(0);
        send_byte(8'h92, 0);
        check("midrst_done", done, 1);
        check("midrst_core", core_reset_n, 1);
        check("midrst_total", n_writes - w0, 2);

        // Reload from DONE and load a second image
        @(posedge clk);
        #1;
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check("rel_core", core_reset_n, 0);
        check("rel_done", done, 0);
        check("rel_err", error, 0);
        check("rel_rdy", sif.in_ready, 1);
        w0 = n_writes;
        stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_q.push_back({20'h00000, 32'hDEADBEEF});
        send_stim(0);
        send_byte(8'h23, 0);
        check("rel2_done", done, 1);
        check("rel2_core", core_reset_n, 1);
        check("rel2_writes", n_writes - w0, 1);
        check("final_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
